// File: rtl/apb_master_param.sv
// APB master: runs one READ / WRITE / RMW-add / NOP command at a time over APB,
// with optional ACCESS wait-state timeout, and returns a single-cycle response.
//
// state  | meaning
// IDLE   | ready for a command
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high until pready or timeout
// RESP   | one-cycle response strobe
module apb_master_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic                pready_i,
  input  logic                pslverr_i,
  input  logic [DATA_W-1:0]   prdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RMW   = 2'b11;

  localparam int STRB_W = DATA_W / 8;
  localparam int AL     = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] AMASK    = ~((ADDR_W'(1) << AL) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   add_q, add_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_to_q, rsp_to_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      add_q      <= '0;
      pwdata_q   <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      add_q      <= add_d;
      pwdata_q   <= pwdata_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    add_d      = add_q;
    pwdata_d   = pwdata_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_to_d   = rsp_to_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d     = cmd_op_i;
          addr_d   = cmd_addr_i;
          add_d    = cmd_wdata_i;
          wr_d     = (cmd_op_i == OP_WRITE);
          pwdata_d = (cmd_op_i == OP_WRITE) ? cmd_wdata_i : '0;
          if (cmd_op_i == OP_NOP) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            rsp_to_d   = 1'b0;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          // A clean RMW read turns straight into the write phase.
          if (op_q == OP_RMW && !wr_q && !pslverr_i) begin
            wr_d     = 1'b1;
            pwdata_d = prdata_i + add_q;
            state_d  = S_SETUP;
          end else begin
            state_d    = S_RESP;
            rsp_data_d = wr_q ? pwdata_q : prdata_i;
            rsp_err_d  = pslverr_i;
            rsp_to_d   = 1'b0;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && !reset;
  assign rsp_valid_o   = (state_q == S_RESP);
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);
  assign pwrite_o      = psel_o && wr_q;
  assign paddr_o       = addr_q & AMASK;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pwrite_o ? {STRB_W{1'b1}} : {STRB_W{1'b0}};

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: directed and random commands against a
// transaction-level model, plus a 64-bit-data instance.
module tb_apb_master_param;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_err, rsp_to;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata, rsp_data;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;

  logic        v_cmd_valid, v_cmd_ready, v_rsp_valid, v_rsp_err, v_rsp_to;
  logic [1:0]  v_cmd_op;
  logic [31:0] v_cmd_addr, v_paddr;
  logic [63:0] v_cmd_wdata, v_rsp_data, v_pwdata, v_prdata;
  logic        v_psel, v_penable, v_pwrite, v_pready, v_pslverr;
  logic [7:0]  v_pstrb;

  apb_master_param #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_to),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );

  apb_master_param #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .reset(reset),
    .cmd_valid_i(v_cmd_valid), .cmd_ready_o(v_cmd_ready), .cmd_op_i(v_cmd_op),
    .cmd_addr_i(v_cmd_addr), .cmd_wdata_i(v_cmd_wdata),
    .rsp_valid_o(v_rsp_valid), .rsp_data_o(v_rsp_data), .rsp_err_o(v_rsp_err),
    .rsp_timeout_o(v_rsp_to),
    .psel_o(v_psel), .penable_o(v_penable), .pwrite_o(v_pwrite),
    .paddr_o(v_paddr), .pwdata_o(v_pwdata), .pstrb_o(v_pstrb),
    .pready_i(v_pready), .pslverr_i(v_pslverr), .prdata_i(v_prdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issues one command, plays the slave (w0/w1 wait states, e0/e1 slverr per phase),
  // and compares what it sees with a transaction-level expectation.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd0, input int w0, input int w1,
                         input logic e0, input logic e1);
    int          nph, exp_cyc, ph, acc, rcyc, unstable, wt, guard;
    int          alen[2], got_len[2];
    logic        pwr[2], got_wr[2];
    logic [31:0] pwd[2], got_addr[2], got_wd[2];
    logic [3:0]  got_strb[2];
    logic [31:0] exp_data, wr_val, r_data;
    logic        exp_err, exp_to, r_err, r_to, r_psel;
    exp_data = '0; exp_err = 1'b0; exp_to = 1'b0; nph = 0;
    wr_val = rd0 + wd;
    alen = '{0, 0}; pwr = '{1'b0, 1'b0}; pwd = '{32'h0, 32'h0};
    if (op != 2'd0) begin
      nph = 1;
      pwr[0] = (op == 2'd2);
      pwd[0] = wd;
      if (w0 >= TO) begin
        alen[0] = TO; exp_to = 1'b1; exp_err = 1'b1;
      end else begin
        alen[0] = w0 + 1;
        if (op == 2'd1) begin exp_data = rd0; exp_err = e0; end
        else if (op == 2'd2) begin exp_data = wd; exp_err = e0; end
        else if (e0) begin exp_data = rd0; exp_err = 1'b1; end
        else begin
          nph = 2; pwr[1] = 1'b1; pwd[1] = wr_val;
          if (w1 >= TO) begin alen[1] = TO; exp_to = 1'b1; exp_err = 1'b1; end
          else begin alen[1] = w1 + 1; exp_data = wr_val; exp_err = e1; end
        end
      end
    end
    exp_cyc = 1;
    for (int i = 0; i < nph; i++) exp_cyc += 1 + alen[i];

    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk);
    ph = -1; acc = 0; rcyc = 0; unstable = 0;
    r_data = '0; r_err = 1'b0; r_to = 1'b0; r_psel = 1'b0;
    got_len = '{0, 0}; got_wr = '{1'b0, 1'b0}; got_addr = '{32'h0, 32'h0};
    got_wd = '{32'h0, 32'h0}; got_strb = '{4'h0, 4'h0};
    for (int c = 1; c <= 80 && rcyc == 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = $urandom;
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      if (psel && !penable) begin
        ph++; acc = 0;
        if (ph < 2) begin
          got_addr[ph] = paddr; got_wr[ph] = pwrite; got_strb[ph] = pstrb; got_wd[ph] = pwdata;
        end
      end else if (psel && penable && ph >= 0 && ph < 2) begin
        acc++;
        got_len[ph] = acc;
        if (paddr !== got_addr[ph] || pwrite !== got_wr[ph] || pstrb !== got_strb[ph] ||
            pwdata !== got_wd[ph]) unstable++;
        wt = (ph == 0) ? w0 : w1;
        if (acc == wt + 1) begin
          pready = 1'b1;
          pslverr = (ph == 0) ? e0 : e1;
          prdata = (ph == 0) ? rd0 : $urandom;
        end else begin
          pready = 1'b0;
        end
      end
      if (rsp_valid) begin
        rcyc = c; r_data = rsp_data; r_err = rsp_err; r_to = rsp_to; r_psel = psel | penable;
      end
    end
    chk("rsp_cycle", 64'(rcyc), 64'(exp_cyc));
    chk("phase_count", 64'(ph + 1), 64'(nph));
    for (int i = 0; i < nph && i < 2; i++) begin
      chk("access_len", 64'(got_len[i]), 64'(alen[i]));
      chk("pwrite", 64'(got_wr[i]), 64'(pwr[i]));
      chk("pstrb", 64'(got_strb[i]), pwr[i] ? 64'hF : 64'h0);
      chk("paddr", 64'(got_addr[i]), 64'(addr & 32'hFFFF_FFFC));
      if (pwr[i]) chk("pwdata", 64'(got_wd[i]), 64'(pwd[i]));
    end
    chk("phase_stable", 64'(unstable), 64'(0));
    chk("rsp_psel_low", 64'(r_psel), 64'(0));
    chk("rsp_data", 64'(r_data), 64'(exp_data));
    chk("rsp_err", 64'(r_err), 64'(exp_err));
    chk("rsp_timeout", 64'(r_to), 64'(exp_to));
    @(negedge clk);
    pready = 1'b0;
    chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
    chk("ready_after_rsp", 64'(cmd_ready), 64'(1));
    chk("rsp_data_hold", 64'(rsp_data), 64'(r_data));
  endtask

  // Zero-wait single command on the 64-bit instance.
  task automatic run64(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input logic [31:0] exp_addr,
                       input logic [7:0] exp_strb, input logic [63:0] exp_data);
    v_cmd_valid = 1'b1; v_cmd_op = op; v_cmd_addr = addr; v_cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    v_cmd_valid = 1'b0;
    chk("w64_setup", 64'({v_psel, v_penable}), 64'(2'b10));
    chk("w64_paddr", 64'(v_paddr), 64'(exp_addr));
    chk("w64_pstrb", 64'(v_pstrb), 64'(exp_strb));
    @(negedge clk);
    chk("w64_access", 64'({v_psel, v_penable}), 64'(2'b11));
    v_pready = 1'b1; v_prdata = rd; v_pslverr = 1'b0;
    @(negedge clk);
    v_pready = 1'b0;
    chk("w64_rsp_valid", 64'(v_rsp_valid), 64'(1));
    chk("w64_rsp_data", v_rsp_data, exp_data);
    chk("w64_rsp_err", 64'(v_rsp_err), 64'(0));
    @(negedge clk);
    chk("w64_ready", 64'(v_cmd_ready), 64'(1));
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 8);
    if (r < 5) return int'($urandom % 4);
    else if (r < 7) return 13 + int'($urandom % 4);
    else return 40;
  endfunction

  initial begin
    logic [1:0]  bops[3];
    logic [31:0] bwd[3];
    logic [31:0] rq[$];
    int          idx, viol, e, n, pulses;
    int          acc_c[3];
    logic        took;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    v_cmd_valid = 1'b0; v_cmd_op = '0; v_cmd_addr = '0; v_cmd_wdata = '0;
    v_pready = 1'b0; v_pslverr = 1'b0; v_prdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(cmd_ready), 64'(0));
    chk("reset_ctrl", 64'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_to, pstrb}), 64'(0));
    chk("reset_data", 64'(paddr | pwdata | rsp_data), 64'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_release", 64'(cmd_ready), 64'(1));
    chk("ready64_after_release", 64'(v_cmd_ready), 64'(1));

    run_cmd(2'd1, 32'h0000_1003, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
    run_cmd(2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0, 1'b0);
    run_cmd(2'd3, 32'h0000_3004, 32'h1, 32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0);
    run_cmd(2'd3, 32'h0000_3008, 32'h5, 32'hAAAA_5555, 2, 0, 1'b1, 1'b0);
    run_cmd(2'd1, 32'h0000_4000, 32'h0, 32'h1111_2222, 40, 0, 1'b0, 1'b0);
    run_cmd(2'd1, 32'h0000_4004, 32'h0, 32'h3333_4444, 15, 0, 1'b1, 1'b0);
    run_cmd(2'd3, 32'h0000_5000, 32'h10, 32'h20, 0, 40, 1'b0, 1'b0);
    run_cmd(2'd0, 32'h0000_6000, 32'h9999, 32'h0, 0, 0, 1'b0, 1'b0);
    run_cmd(2'd2, 32'h0000_7002, 32'h0F0F_0F0F, 32'h0, 1, 0, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++)
      run_cmd(2'($urandom), $urandom, $urandom, $urandom, pick_wait(), pick_wait(),
              ($urandom % 4) == 0, ($urandom % 4) == 0);

    // Reset while a transfer sits in ACCESS.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 32'h0000_8000;
    @(posedge clk); #1;
    cmd_valid = 1'b0; pready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(psel && penable) && n < 10);
    chk("reach_access", 64'(psel && penable), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_abort_psel", 64'({psel, penable}), 64'(0));
    chk("rst_abort_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_abort_ready", 64'(cmd_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(cmd_ready), 64'(1));
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || psel) pulses++;
    end
    chk("rst_no_rsp", 64'(pulses), 64'(0));

    // Back-to-back with cmd_valid held high.
    bops = '{2'd1, 2'd2, 2'd0};
    bwd  = '{32'h0, 32'h0BAD_F00D, 32'h7777};
    idx = 0; viol = 0; acc_c = '{-1, -1, -1};
    cmd_valid = 1'b1; cmd_op = bops[0]; cmd_addr = 32'h0000_9000; cmd_wdata = bwd[0];
    for (int c = 0; c < 40 && rq.size() < 3; c++) begin
      pready = psel && penable; prdata = 32'hCAFE_0001; pslverr = 1'b0;
      if (psel && cmd_ready) viol++;
      if (rsp_valid) rq.push_back(rsp_data);
      took = cmd_valid && cmd_ready;
      if (took && idx < 3) acc_c[idx] = c;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 3) begin cmd_op = bops[idx]; cmd_wdata = bwd[idx]; end
        else cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; pready = 1'b0;
    chk("b2b_ready_only_idle", 64'(viol), 64'(0));
    e = 0;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_accept_cycle", 64'(acc_c[i]), 64'(e));
      e += (bops[i] == 2'd0) ? 2 : 4;
    end
    chk("b2b_rsp_count", 64'(rq.size()), 64'(3));
    if (rq.size() == 3) begin
      chk("b2b_rsp0", 64'(rq[0]), 64'h0000_0000_CAFE_0001);
      chk("b2b_rsp1", 64'(rq[1]), 64'(bwd[1]));
      chk("b2b_rsp2", 64'(rq[2]), 64'(0));
    end

    run64(2'd1, 32'h0000_1003, 64'h0, 64'hA5A5_0000_1234_5678, 32'h0000_1000, 8'h00,
          64'hA5A5_0000_1234_5678);
    run64(2'd2, 32'h0000_100F, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h0000_1008, 8'hFF,
          64'h0123_4567_89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
